// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared state encoding, oversample constants and parity helper for uart_rx_async
package uart_rx_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PARITY,
    ST_STOP,
    ST_BRK_WAIT
  } rx_state_e;

  localparam int         OVERSAMPLE  = 16;
  localparam logic [3:0] MID_SAMPLE  = 4'd7;
  localparam logic [3:0] LAST_SAMPLE = 4'(OVERSAMPLE - 1);

  // Even-parity sum of the data bits in use; callers xor in odd_n_even.
  function automatic logic calc_parity(input logic [7:0] data, input logic bit8);
    return bit8 ? ^data : ^data[6:0];
  endfunction

endpackage

// File: rtl/uart_rx_filter.sv
// rtl/uart_rx_filter.sv - rx synchroniser plus 3-sample majority filter clocked by baud_clock
module uart_rx_filter #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic reset,
  input  logic baud_clock,
  input  logic rx,
  output logic frx
);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic [2:0]             hist_q, hist_d;

  always_comb begin
    sync_d = {sync_q[SYNC_STAGES-2:0], rx};
    hist_d = hist_q;
    if (baud_clock) begin
      hist_d = {hist_q[1:0], sync_q[SYNC_STAGES-1]};
    end
  end

  // Reset to the idle-high line level so a reset never looks like a start edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q <= '1;
      hist_q <= 3'b111;
    end else begin
      sync_q <= sync_d;
      hist_q <= hist_d;
    end
  end

  assign frx = (hist_q[0] & hist_q[1]) | (hist_q[0] & hist_q[2]) | (hist_q[1] & hist_q[2]);

endmodule

// File: rtl/uart_rx_async.sv
// rtl/uart_rx_async.sv - 16x oversampling UART receiver with holding register or external FIFO delivery
module uart_rx_async
  import uart_rx_pkg::*;
#(
  parameter int RX_FIFO     = 0,
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       baud_clock,
  input  logic       rx,
  input  logic       bit8,
  input  logic       parity_en,
  input  logic       odd_n_even,
  input  logic       read_rx_byte,
  input  logic       fifo_full,
  output logic [7:0] rx_byte,
  output logic       rx_ready,
  output logic       fifo_write,
  output logic       parity_err,
  output logic       framing_err,
  output logic       overflow,
  output logic       rx_idle
);

  logic frx;

  uart_rx_filter #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_filter (
    .clk        (clk),
    .reset      (reset),
    .baud_clock (baud_clock),
    .rx         (rx),
    .frx        (frx)
  );

  rx_state_e  state_q, state_d;
  logic [3:0] samp_cnt_q, samp_cnt_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic       bit8_q, bit8_d;
  logic       parity_en_q, parity_en_d;
  logic       odd_q, odd_d;
  logic       par_pend_q, par_pend_d;
  logic [7:0] rx_byte_q, rx_byte_d;
  logic       rx_ready_q, rx_ready_d;
  logic       fifo_write_q, fifo_write_d;
  logic       parity_err_q, parity_err_d;
  logic       framing_err_q, framing_err_d;
  logic       overflow_q, overflow_d;

  logic       deliver;
  logic [2:0] data_last;
  logic [7:0] byte_asm;

  // Bits enter at bit 7, so a 7-bit frame sits in [7:1] and needs one more shift.
  assign data_last = bit8_q ? 3'd7 : 3'd6;
  assign byte_asm  = bit8_q ? shift_q : {1'b0, shift_q[7:1]};

  always_comb begin
    state_d       = state_q;
    samp_cnt_d    = samp_cnt_q;
    bit_cnt_d     = bit_cnt_q;
    shift_d       = shift_q;
    bit8_d        = bit8_q;
    parity_en_d   = parity_en_q;
    odd_d         = odd_q;
    par_pend_d    = par_pend_q;
    rx_byte_d     = rx_byte_q;
    rx_ready_d    = rx_ready_q;
    fifo_write_d  = 1'b0;
    parity_err_d  = parity_err_q;
    framing_err_d = framing_err_q;
    overflow_d    = overflow_q;
    deliver       = 1'b0;

    if (read_rx_byte) begin
      rx_ready_d    = 1'b0;
      parity_err_d  = 1'b0;
      framing_err_d = 1'b0;
      overflow_d    = 1'b0;
    end

    if (baud_clock) begin
      case (state_q)
        ST_IDLE: begin
          if (!frx) begin
            state_d    = ST_START;
            samp_cnt_d = 4'd0;
          end
        end
        ST_START: begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == MID_SAMPLE) begin
            samp_cnt_d = 4'd0;
            if (frx) begin
              state_d = ST_IDLE;
            end else begin
              state_d     = ST_DATA;
              bit_cnt_d   = 3'd0;
              bit8_d      = bit8;
              parity_en_d = parity_en;
              odd_d       = odd_n_even;
              par_pend_d  = 1'b0;
            end
          end
        end
        ST_DATA: begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == LAST_SAMPLE) begin
            shift_d = {frx, shift_q[7:1]};
            if (bit_cnt_q == data_last) begin
              state_d = parity_en_q ? ST_PARITY : ST_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + 3'd1;
            end
          end
        end
        ST_PARITY: begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == LAST_SAMPLE) begin
            par_pend_d = frx ^ calc_parity(byte_asm, bit8_q) ^ odd_q;
            state_d    = ST_STOP;
          end
        end
        ST_STOP: begin
          samp_cnt_d = samp_cnt_q + 4'd1;
          if (samp_cnt_q == LAST_SAMPLE) begin
            deliver = 1'b1;
            state_d = frx ? ST_IDLE : ST_BRK_WAIT;
          end
        end
        ST_BRK_WAIT: begin
          if (frx) begin
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end

    // Delivery is evaluated after the clear so a same-cycle load or overflow wins.
    if (deliver) begin
      if (RX_FIFO == 0) begin
        if (!rx_ready_q || read_rx_byte) begin
          rx_byte_d     = byte_asm;
          parity_err_d  = par_pend_q;
          framing_err_d = ~frx;
          rx_ready_d    = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end else begin
        if (!fifo_full) begin
          rx_byte_d     = byte_asm;
          parity_err_d  = par_pend_q;
          framing_err_d = ~frx;
          fifo_write_d  = 1'b1;
        end else begin
          overflow_d = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      samp_cnt_q    <= 4'd0;
      bit_cnt_q     <= 3'd0;
      shift_q       <= 8'h00;
      bit8_q        <= 1'b0;
      parity_en_q   <= 1'b0;
      odd_q         <= 1'b0;
      par_pend_q    <= 1'b0;
      rx_byte_q     <= 8'h00;
      rx_ready_q    <= 1'b0;
      fifo_write_q  <= 1'b0;
      parity_err_q  <= 1'b0;
      framing_err_q <= 1'b0;
      overflow_q    <= 1'b0;
    end else begin
      state_q       <= state_d;
      samp_cnt_q    <= samp_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      bit8_q        <= bit8_d;
      parity_en_q   <= parity_en_d;
      odd_q         <= odd_d;
      par_pend_q    <= par_pend_d;
      rx_byte_q     <= rx_byte_d;
      rx_ready_q    <= rx_ready_d;
      fifo_write_q  <= fifo_write_d;
      parity_err_q  <= parity_err_d;
      framing_err_q <= framing_err_d;
      overflow_q    <= overflow_d;
    end
  end

  assign rx_byte     = rx_byte_q;
  assign rx_ready    = rx_ready_q;
  assign fifo_write  = fifo_write_q;
  assign parity_err  = parity_err_q;
  assign framing_err = framing_err_q;
  assign overflow    = overflow_q;
  assign rx_idle     = (state_q == ST_IDLE);

endmodule

// File: tb/tb_uart_rx_async.sv
// tb/tb_uart_rx_async.sv - directed bench for uart_rx_async in holding-register and FIFO modes
module tb_uart_rx_async;

  localparam int BIT_CLKS = 64;  // 16 baud ticks of 4 clk each

  logic       clk;
  logic       reset;
  logic       baud_clock;
  logic       rx;
  logic       bit8;
  logic       parity_en;
  logic       odd_n_even;
  logic       read_rx_byte;
  logic       fifo_full;

  logic [7:0] rx_byte,   rx_byte_f;
  logic       rx_ready,  rx_ready_f;
  logic       fifo_write, fifo_write_f;
  logic       parity_err, parity_err_f;
  logic       framing_err, framing_err_f;
  logic       overflow,  overflow_f;
  logic       rx_idle,   rx_idle_f;

  int n_checks = 0;
  int n_fail   = 0;
  int wr_cnt   = 0;
  logic [7:0] last_wr_byte = 8'h00;
  int wr_base;

  uart_rx_async #(.RX_FIFO(0), .SYNC_STAGES(2)) u_dut (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .fifo_full(fifo_full),
    .rx_byte(rx_byte), .rx_ready(rx_ready), .fifo_write(fifo_write),
    .parity_err(parity_err), .framing_err(framing_err),
    .overflow(overflow), .rx_idle(rx_idle)
  );

  uart_rx_async #(.RX_FIFO(1), .SYNC_STAGES(2)) u_dut_fifo (
    .clk(clk), .reset(reset), .baud_clock(baud_clock), .rx(rx),
    .bit8(bit8), .parity_en(parity_en), .odd_n_even(odd_n_even),
    .read_rx_byte(read_rx_byte), .fifo_full(fifo_full),
    .rx_byte(rx_byte_f), .rx_ready(rx_ready_f), .fifo_write(fifo_write_f),
    .parity_err(parity_err_f), .framing_err(framing_err_f),
    .overflow(overflow_f), .rx_idle(rx_idle_f)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    baud_clock = 1'b0;
    forever begin
      repeat (3) @(negedge clk);
      baud_clock = 1'b1;
      @(negedge clk);
      baud_clock = 1'b0;
    end
  end

  always @(negedge clk) begin
    if (fifo_write_f) begin
      wr_cnt       <= wr_cnt + 1;
      last_wr_byte <= rx_byte_f;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic drive_bit(input logic v);
    rx = v;
    repeat (BIT_CLKS) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits, input bit has_par,
                            input logic par_bit, input logic stop_bit);
    drive_bit(1'b0);
    for (int i = 0; i < nbits; i++) drive_bit(data[i]);
    if (has_par) drive_bit(par_bit);
    drive_bit(stop_bit);
    if (stop_bit) drive_bit(1'b1);
  endtask

  task automatic pulse_read;
    read_rx_byte = 1'b1;
    @(negedge clk);
    read_rx_byte = 1'b0;
  endtask

  initial begin
    reset        = 1'b1;
    rx           = 1'b1;
    bit8         = 1'b1;
    parity_en    = 1'b0;
    odd_n_even   = 1'b0;
    read_rx_byte = 1'b0;
    fifo_full    = 1'b0;
    repeat (4) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    check("rst_rx_byte",  rx_byte,      8'h00);
    check("rst_ready",    rx_ready,     1'b0);
    check("rst_perr",     parity_err,   1'b0);
    check("rst_ferr",     framing_err,  1'b0);
    check("rst_ovf",      overflow,     1'b0);
    check("rst_idle",     rx_idle,      1'b1);
    check("rst_fwrite",   fifo_write_f, 1'b0);
    drive_bit(1'b1);

    // 0xA5, 8N1
    send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b1);
    check("a5_byte",  rx_byte,     8'hA5);
    check("a5_ready", rx_ready,    1'b1);
    check("a5_perr",  parity_err,  1'b0);
    check("a5_ferr",  framing_err, 1'b0);
    check("a5_idle",  rx_idle,     1'b1);
    pulse_read();
    check("a5_read_ready", rx_ready, 1'b0);

    // Short glitch: start detected but rejected at mid-bit
    rx = 1'b0;
    repeat (12) @(negedge clk);
    rx = 1'b1;
    repeat (8) @(negedge clk);
    check("fs_started", rx_idle, 1'b0);
    repeat (2 * BIT_CLKS) @(negedge clk);
    check("fs_idle",  rx_idle,  1'b1);
    check("fs_ready", rx_ready, 1'b0);

    // 7-bit odd parity: 0x3C has four ones, so the correct parity bit is 1
    bit8 = 1'b0; parity_en = 1'b1; odd_n_even = 1'b1;
    send_frame(8'h3C, 7, 1'b1, 1'b0, 1'b1);
    check("p_bad_byte", rx_byte,    8'h3C);
    check("p_bad_perr", parity_err, 1'b1);
    check("p_bad_rdy",  rx_ready,   1'b1);
    pulse_read();
    check("p_clr_perr", parity_err, 1'b0);
    send_frame(8'h3C, 7, 1'b1, 1'b1, 1'b1);
    check("p_ok_byte", rx_byte,    8'h3C);
    check("p_ok_perr", parity_err, 1'b0);
    pulse_read();
    // 7-bit mode forces bit 7 to 0
    send_frame(8'hFF, 7, 1'b1, 1'b0, 1'b1);
    check("p7_byte", rx_byte,    8'h7F);
    check("p7_perr", parity_err, 1'b0);
    pulse_read();

    // Break: stop bit 0 followed by a long low line
    bit8 = 1'b1; parity_en = 1'b0; odd_n_even = 1'b0;
    send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0);
    repeat (20 * BIT_CLKS) @(negedge clk);
    check("brk_ferr",  framing_err, 1'b1);
    check("brk_byte",  rx_byte,     8'h55);
    check("brk_ovf",   overflow,    1'b0);
    check("brk_wait",  rx_idle,     1'b0);
    pulse_read();
    check("brk_clr_ferr", framing_err, 1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    check("brk_idle",  rx_idle,  1'b1);
    check("brk_ready", rx_ready, 1'b0);

    // Overflow in holding-register mode
    send_frame(8'h11, 8, 1'b0, 1'b0, 1'b1);
    send_frame(8'h22, 8, 1'b0, 1'b0, 1'b1);
    check("ovf_byte",  rx_byte,  8'h11);
    check("ovf_flag",  overflow, 1'b1);
    check("ovf_ready", rx_ready, 1'b1);
    pulse_read();
    check("ovf_clr_ready", rx_ready, 1'b0);
    check("ovf_clr_flag",  overflow, 1'b0);

    // FIFO mode
    fifo_full = 1'b0;
    wr_base = wr_cnt;
    send_frame(8'h7E, 8, 1'b0, 1'b0, 1'b1);
    check("fifo_wr_cnt",  32'(wr_cnt - wr_base), 32'd1);
    check("fifo_wr_byte", last_wr_byte, 8'h7E);
    check("fifo_ready0",  rx_ready_f,   1'b0);
    fifo_full = 1'b1;
    wr_base = wr_cnt;
    send_frame(8'h81, 8, 1'b0, 1'b0, 1'b1);
    check("fifo_full_wr",   32'(wr_cnt - wr_base), 32'd0);
    check("fifo_full_ovf",  overflow_f, 1'b1);
    check("fifo_full_byte", rx_byte_f,  8'h7E);
    check("main_ovf_81",    overflow,   1'b1);
    fifo_full = 1'b0;

    // Reset in the middle of the data bits
    rx = 1'b0;
    repeat (BIT_CLKS) @(negedge clk);
    rx = 1'b1;
    repeat (40) @(negedge clk);
    check("mid_busy", rx_idle, 1'b0);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("mid_idle",   rx_idle,    1'b1);
    check("mid_ready",  rx_ready,   1'b0);
    check("mid_ovf",    overflow,   1'b0);
    check("mid_byte",   rx_byte,    8'h00);
    check("mid_ovf_f",  overflow_f, 1'b0);
    drive_bit(1'b1);
    drive_bit(1'b1);
    send_frame(8'hC3, 8, 1'b0, 1'b0, 1'b1);
    check("c3_byte",  rx_byte,     8'hC3);
    check("c3_ready", rx_ready,    1'b1);
    check("c3_perr",  parity_err,  1'b0);
    check("c3_ferr",  framing_err, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
